// File: rtl/dram_pkg.sv
// Shared definitions for the multi-bank DRAM controller.
//   cmd_t   : DRAM command encoding driven on the controller's cmd port
//   state_t : controller FSM state encoding
//   field_w : bit width of one address field (bank, row or column)
//   addr_w  : total request address width, {bank,row,col} MSB to LSB
package dram_pkg;

   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4,
      CMD_REF = 3'd5
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRE      = 3'd1,
      S_ACT      = 3'd2,
      S_WAIT_RCD = 3'd3,
      S_ACCESS   = 3'd4,
      S_REFRESH  = 3'd5
   } state_t;

   // A field of one entry still needs one bit to be addressable.
   function automatic int field_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int addr_w(input int banks, input int rows, input int cols);
      return field_w(banks) + field_w(rows) + field_w(cols);
   endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// Request queue for the DRAM controller: show-ahead FIFO, the head entry
// is visible on head whenever empty is low.
//   clk, rst_b       : clock, asynchronous active-low reset
//   push, push_data  : write an entry (dropped when full unless popping)
//   pop              : discard the head entry
//   head             : current head entry
//   full, empty      : occupancy flags
module dram_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a full queue may still take a push.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/dram_ctrl_mb.sv
// Multi-bank DRAM controller with per-bank open-row tracking and periodic refresh.
// Optional feature macro: DRAM_CTRL_OPEN_PAGE_EN (rows stay open after an access;
// without it every access is followed by a PRE to that bank).
//   clk, rst_b                    : clock, asynchronous active-low reset
//   req_valid/req_ready/req_we    : request handshake, 1 = write
//   req_addr, req_wdata           : {bank,row,col} address, write data
//   rsp_valid, rsp_data           : read return, one cycle after RD
//   dram_data_in, dram_data_out   : DRAM data buses
//   cmd, bank_sel/row_sel/col_sel : command and one-hot selects (all zero on NOP)
//   refresh_busy                  : high from leaving IDLE for refresh through REF
module dram_ctrl_mb
   import dram_pkg::*;
#(
   parameter int NUM_OF_BANKS   = 8,
   parameter int NUM_OF_ROWS    = 128,
   parameter int NUM_OF_COLS    = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int REQ_DEPTH      = 4,
   parameter int T_RCD          = 2,
   parameter int REFRESH_PERIOD = 1024
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [addr_w(NUM_OF_BANKS, NUM_OF_ROWS, NUM_OF_COLS)-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   input  logic [DATA_WIDTH-1:0]   dram_data_in,
   output logic [DATA_WIDTH-1:0]   dram_data_out,
   output logic [2:0]              cmd,
   output logic [NUM_OF_BANKS-1:0] bank_sel,
   output logic [NUM_OF_ROWS-1:0]  row_sel,
   output logic [NUM_OF_COLS-1:0]  col_sel,
   output logic                    refresh_busy
);

   localparam int BW    = field_w(NUM_OF_BANKS);
   localparam int RW    = field_w(NUM_OF_ROWS);
   localparam int CW    = field_w(NUM_OF_COLS);
   localparam int AW    = BW + RW + CW;
   localparam int FW    = 1 + AW + DATA_WIDTH;
   localparam int RCD_W = field_w(T_RCD);
   localparam int REF_W = field_w(REFRESH_PERIOD);

   state_t                  state;
   state_t                  after_pre;
   logic [FW-1:0]           head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    head_we;
   logic [AW-1:0]           head_addr;
   logic [DATA_WIDTH-1:0]   head_wdata;
   logic [BW-1:0]           head_bank;
   logic [RW-1:0]           head_row;
   logic [CW-1:0]           head_col;
   logic [NUM_OF_BANKS-1:0] head_bank_oh;
   logic [NUM_OF_ROWS-1:0]  head_row_oh;
   logic [NUM_OF_COLS-1:0]  head_col_oh;
   logic [NUM_OF_BANKS-1:0] cur_bank_oh;
   logic [BW-1:0]           cur_bank;
   logic [NUM_OF_BANKS-1:0] bank_open;
   logic [RW-1:0]           open_row [NUM_OF_BANKS];
   logic                    row_hit;
   logic [2:0]              acc_cmd;
   logic [DATA_WIDTH-1:0]   acc_data;
   logic [RCD_W-1:0]        rcd_cnt;
   logic [REF_W-1:0]        ref_cnt;
   logic                    ref_wrap;
   logic                    ref_pending;

   // Only a real handshake enqueues, so a requester never sees a dropped accept.
   assign req_ready = !fifo_full;
   assign pop       = (state == S_ACCESS);

   dram_req_fifo #(.WIDTH(FW), .DEPTH(REQ_DEPTH)) u_req_fifo (
      .clk       (clk),
      .rst_b     (rst_b),
      .push      (req_valid && req_ready),
      .push_data ({req_we, req_addr, req_wdata}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign {head_we, head_addr, head_wdata} = head;
   assign head_bank = head_addr[AW-1 -: BW];
   assign head_row  = head_addr[CW +: RW];
   assign head_col  = head_addr[CW-1:0];
   assign row_hit   = bank_open[head_bank] && (open_row[head_bank] == head_row);
   assign acc_cmd   = head_we ? CMD_WR : CMD_RD;
   assign acc_data  = head_we ? head_wdata : '0;

   always_comb begin
      head_bank_oh = '0;
      head_bank_oh[head_bank] = 1'b1;
      head_row_oh = '0;
      head_row_oh[head_row] = 1'b1;
      head_col_oh = '0;
      head_col_oh[head_col] = 1'b1;
      cur_bank_oh = '0;
      cur_bank_oh[cur_bank] = 1'b1;
   end

   assign ref_wrap = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) ref_cnt <= '0;
      else        ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
   end

   // Commands and selects are registered together with the state, so each
   // state that issues a command shows it for exactly its one cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state         <= S_IDLE;
         after_pre     <= S_IDLE;
         cmd           <= CMD_NOP;
         bank_sel      <= '0;
         row_sel       <= '0;
         col_sel       <= '0;
         dram_data_out <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         refresh_busy  <= 1'b0;
         ref_pending   <= 1'b0;
         bank_open     <= '0;
         cur_bank      <= '0;
         rcd_cnt       <= '0;
         for (int b = 0; b < NUM_OF_BANKS; b++) open_row[b] <= '0;
      end else begin
         cmd           <= CMD_NOP;
         bank_sel      <= '0;
         row_sel       <= '0;
         col_sel       <= '0;
         dram_data_out <= '0;
         // The DRAM returns data during the RD cycle; capture it at its end.
         rsp_valid     <= (cmd == CMD_RD);
         if (cmd == CMD_RD) rsp_data <= dram_data_in;

         case (state)
            S_IDLE: begin
               if (ref_pending) begin
                  refresh_busy <= 1'b1;
                  if (|bank_open) begin
                     cmd       <= CMD_PRE;
                     bank_sel  <= '1;
                     bank_open <= '0;
                     after_pre <= S_REFRESH;
                     state     <= S_PRE;
                  end else begin
                     cmd         <= CMD_REF;
                     ref_pending <= 1'b0;
                     state       <= S_REFRESH;
                  end
               end else if (!fifo_empty) begin
                  cur_bank <= head_bank;
                  if (row_hit) begin
                     cmd           <= acc_cmd;
                     bank_sel      <= head_bank_oh;
                     col_sel       <= head_col_oh;
                     dram_data_out <= acc_data;
                     state         <= S_ACCESS;
                  end else if (bank_open[head_bank]) begin
                     cmd                  <= CMD_PRE;
                     bank_sel             <= head_bank_oh;
                     bank_open[head_bank] <= 1'b0;
                     after_pre            <= S_ACT;
                     state                <= S_PRE;
                  end else begin
                     cmd                  <= CMD_ACT;
                     bank_sel             <= head_bank_oh;
                     row_sel              <= head_row_oh;
                     bank_open[head_bank] <= 1'b1;
                     open_row[head_bank]  <= head_row;
                     state                <= S_ACT;
                  end
               end
            end
            S_PRE: begin
               if (after_pre == S_ACT) begin
                  cmd                  <= CMD_ACT;
                  bank_sel             <= head_bank_oh;
                  row_sel              <= head_row_oh;
                  bank_open[head_bank] <= 1'b1;
                  open_row[head_bank]  <= head_row;
                  state                <= S_ACT;
               end else if (after_pre == S_REFRESH) begin
                  cmd         <= CMD_REF;
                  ref_pending <= 1'b0;
                  state       <= S_REFRESH;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_ACT: begin
               if (T_RCD <= 1) begin
                  cmd           <= acc_cmd;
                  bank_sel      <= head_bank_oh;
                  col_sel       <= head_col_oh;
                  dram_data_out <= acc_data;
                  state         <= S_ACCESS;
               end else begin
                  rcd_cnt <= RCD_W'(T_RCD - 2);
                  state   <= S_WAIT_RCD;
               end
            end
            S_WAIT_RCD: begin
               if (rcd_cnt == '0) begin
                  cmd           <= acc_cmd;
                  bank_sel      <= head_bank_oh;
                  col_sel       <= head_col_oh;
                  dram_data_out <= acc_data;
                  state         <= S_ACCESS;
               end else begin
                  rcd_cnt <= rcd_cnt - 1'b1;
               end
            end
            S_ACCESS: begin
`ifdef DRAM_CTRL_OPEN_PAGE_EN
               state <= S_IDLE;
`else
               cmd                 <= CMD_PRE;
               bank_sel            <= cur_bank_oh;
               bank_open[cur_bank] <= 1'b0;
               after_pre           <= S_IDLE;
               state               <= S_PRE;
`endif
            end
            S_REFRESH: begin
               refresh_busy <= 1'b0;
               bank_open    <= '0;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // A wrap in the same cycle as REF starts a fresh refresh interval.
         if (ref_wrap) ref_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dram_ctrl_mb.sv
// Self-checking bench for dram_ctrl_mb: stimulus pushes expected commands and
// read returns into queues; a monitor compares them as the DUT emits them.
// Honours DRAM_CTRL_OPEN_PAGE_EN for the page-policy dependent sequences.
module tb_dram_ctrl_mb;

   localparam int C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5;

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_we = 1'b0;
   logic [12:0]  req_addr = '0;
   logic [7:0]   req_wdata = '0;
   logic         rsp_valid;
   logic [7:0]   rsp_data;
   logic [7:0]   dram_data_in;
   logic [7:0]   dram_data_out;
   logic [2:0]   cmd;
   logic [7:0]   bank_sel;
   logic [127:0] row_sel;
   logic [7:0]   col_sel;
   logic         refresh_busy;

   dram_ctrl_mb #(.REFRESH_PERIOD(300)) dut (
      .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .dram_data_in(dram_data_in),
      .dram_data_out(dram_data_out), .cmd(cmd), .bank_sel(bank_sel),
      .row_sel(row_sel), .col_sel(col_sel), .refresh_busy(refresh_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input bit ok, input string detail);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   // DRAM model: remembers the activated row per bank, returns data during RD.
   logic [7:0] mem [8192];
   int         open_r [8];

   function automatic int oh_idx(input logic [127:0] v);
      for (int i = 0; i < 128; i++) if (v[i]) return i;
      return 0;
   endfunction

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
      for (int i = 0; i < 8; i++) open_r[i] = 0;
   end

   always @(negedge clk) begin
      if (rst_b) begin
         if (cmd == 3'(C_ACT)) open_r[oh_idx(128'(bank_sel))] = oh_idx(row_sel);
         if (cmd == 3'(C_WR))
            mem[oh_idx(128'(bank_sel))*1024 + open_r[oh_idx(128'(bank_sel))]*8 + oh_idx(128'(col_sel))] = dram_data_out;
      end
   end

   always_comb begin
      dram_data_in = 8'h00;
      if (cmd == 3'(C_RD))
         dram_data_in = mem[oh_idx(128'(bank_sel))*1024 + open_r[oh_idx(128'(bank_sel))]*8 + oh_idx(128'(col_sel))];
   end

   // Expected command: bank -1 means all banks, -2 / row / col / data / gap -1 means not checked.
   typedef struct {
      int c; int bank; int row; int col; int data; int gap; bit busy;
   } ev_t;

   ev_t        evq [$];
   logic [7:0] rspq [$];

   task automatic ex(input int c, input int b, input int r, input int col,
                     input int d, input int gap, input bit busy);
      ev_t e;
      e.c = c; e.bank = b; e.row = r; e.col = col; e.data = d; e.gap = gap; e.busy = busy;
      evq.push_back(e);
   endtask

   task automatic ex_act(input int b, input int r, input int gap);
      ex(C_ACT, b, r, -1, -1, gap, 1'b0);
   endtask
   task automatic ex_rd(input int b, input int col, input int gap, input logic [7:0] d);
      ex(C_RD, b, -1, col, -1, gap, 1'b0);
      rspq.push_back(d);
   endtask
   task automatic ex_wr(input int b, input int col, input int d, input int gap);
      ex(C_WR, b, -1, col, d, gap, 1'b0);
   endtask
   task automatic ex_close(input int b);
`ifndef DRAM_CTRL_OPEN_PAGE_EN
      ex(C_PRE, b, -1, -1, -1, 1, 1'b0);
`endif
   endtask

   // Monitor
   ev_t  mon_e;
   logic mon_ok;
   int   last_cmd_cyc = -1000;
   int   last_rd_cyc = -1000;

   always @(negedge clk) begin
      if (rst_b) begin
         if (cmd != 3'd0) begin
            if (evq.size() == 0) begin
               check("unexpected_cmd", 1'b0, $sformatf("got cmd=%0d bank_sel=%h, need no command", cmd, bank_sel));
            end else begin
               mon_e = evq.pop_front();
               mon_ok = (cmd == 3'(mon_e.c)) && (refresh_busy == mon_e.busy);
               if (mon_e.bank == -1) mon_ok = mon_ok && (bank_sel == 8'hFF);
               else if (mon_e.bank >= 0) mon_ok = mon_ok && (bank_sel == (8'd1 << mon_e.bank));
               if (mon_e.row >= 0) mon_ok = mon_ok && (row_sel == (128'd1 << mon_e.row));
               if (mon_e.col >= 0) mon_ok = mon_ok && (col_sel == (8'd1 << mon_e.col));
               if (mon_e.data >= 0) mon_ok = mon_ok && (dram_data_out == 8'(mon_e.data));
               if (mon_e.gap >= 0) mon_ok = mon_ok && ((cyc - last_cmd_cyc) == mon_e.gap);
               check("cmd_seq", mon_ok,
                  $sformatf("got cmd=%0d bank_sel=%h row_sel=%h col_sel=%h dout=%h busy=%b gap=%0d; need cmd=%0d bank=%0d row=%0d col=%0d data=%0d gap=%0d busy=%0d",
                     cmd, bank_sel, row_sel, col_sel, dram_data_out, refresh_busy, cyc - last_cmd_cyc,
                     mon_e.c, mon_e.bank, mon_e.row, mon_e.col, mon_e.data, mon_e.gap, mon_e.busy));
            end
            last_cmd_cyc = cyc;
            if (cmd == 3'(C_RD)) last_rd_cyc = cyc;
         end
         if (rsp_valid) begin
            if (rspq.size() == 0) begin
               check("unexpected_rsp", 1'b0, $sformatf("got rsp_data=%h, need no response", rsp_data));
            end else begin
               logic [7:0] exp_d;
               exp_d = rspq.pop_front();
               check("rsp", (rsp_data == exp_d) && (cyc == last_rd_cyc + 1),
                  $sformatf("got data=%h at RD+%0d, need data=%h at RD+1", rsp_data, cyc - last_rd_cyc, exp_d));
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      req_valid = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
   endtask

   task automatic send(input bit we, input int b, input int r, input int c, input logic [7:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = 13'(b*1024 + r*8 + c);
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (k < 200 && (evq.size() != 0 || rspq.size() != 0)) begin
         @(negedge clk);
         k++;
      end
      repeat (4) @(negedge clk);
      check(name, (evq.size() == 0) && (rspq.size() == 0),
         $sformatf("got %0d commands and %0d responses outstanding, need 0 and 0", evq.size(), rspq.size()));
      evq.delete();
      rspq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, need completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      check("rst_cmd", cmd == 3'd0, $sformatf("got %0d, need 0", cmd));
      check("rst_sel", (bank_sel == '0) && (row_sel == '0) && (col_sel == '0),
         $sformatf("got %h/%h/%h, need zeros", bank_sel, row_sel, col_sel));
      check("rst_rsp", (rsp_valid == 1'b0) && (rsp_data == 8'h00),
         $sformatf("got valid=%b data=%h, need 0/00", rsp_valid, rsp_data));
      check("rst_dout", dram_data_out == 8'h00, $sformatf("got %h, need 00", dram_data_out));
      check("rst_busy", refresh_busy == 1'b0, $sformatf("got %b, need 0", refresh_busy));
      check("rst_ready", req_ready == 1'b1, $sformatf("got %b, need 1", req_ready));

      // First read from reset: bank 3 row 5 col 2
      ex_act(3, 5, -1);
      ex_rd(3, 2, 2, 8'h70);
      ex_close(3);
      send(1'b0, 3, 5, 2, 8'h00);
      drain("drain_first_read");

      // Write then read back the same location
      do_reset();
      ex_act(1, 2, -1);
      ex_wr(1, 3, 8'hA5, 2);
      ex_close(1);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      ex_rd(1, 3, -1, 8'hA5);
`else
      ex_act(1, 2, -1);
      ex_rd(1, 3, 2, 8'hA5);
      ex_close(1);
`endif
      send(1'b1, 1, 2, 3, 8'hA5);
      send(1'b0, 1, 2, 3, 8'h00);
      drain("drain_write_read");

      // Same-row reads, then a different row in the same bank
      do_reset();
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      ex_act(3, 5, -1);
      ex_rd(3, 2, 2, 8'h70);
      ex_rd(3, 7, -1, 8'h75);
      ex(C_PRE, 3, -1, -1, -1, -1, 1'b0);
      ex_act(3, 9, 1);
      ex_rd(3, 1, 2, 8'h13);
`else
      ex_act(3, 5, -1); ex_rd(3, 2, 2, 8'h70); ex_close(3);
      ex_act(3, 5, -1); ex_rd(3, 7, 2, 8'h75); ex_close(3);
      ex_act(3, 9, -1); ex_rd(3, 1, 2, 8'h13); ex_close(3);
`endif
      send(1'b0, 3, 5, 2, 8'h00);
      send(1'b0, 3, 5, 7, 8'h00);
      send(1'b0, 3, 9, 1, 8'h00);
      drain("drain_row_policy");

      // Five back-to-back pushes into a four-entry queue
      do_reset();
      ex_act(0, 1, -1); ex_rd(0, 0, 2, 8'h52); ex_close(0);
      ex_act(1, 1, -1); ex_rd(1, 1, 2, 8'h53); ex_close(1);
      ex_act(2, 1, -1); ex_rd(2, 2, 2, 8'h50); ex_close(2);
      ex_act(4, 1, -1); ex_rd(4, 3, 2, 8'h51); ex_close(4);
      for (int i = 0; i < 5; i++) begin
         int bk;
         bk = (i < 3) ? i : i + 1;
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 13'(bk*1024 + 8 + i);
         check($sformatf("ready_push%0d", i), req_ready == (i < 4),
            $sformatf("got %b, need %b", req_ready, (i < 4)));
      end
      @(negedge clk);
      req_valid = 1'b0;
      drain("drain_full_queue");

      // Refresh with bank 1 holding a row
      do_reset();
      ex_act(1, 2, -1);
      ex_rd(1, 0, 2, 8'h4A);
      ex_close(1);
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      ex(C_PRE, -1, -1, -1, -1, -1, 1'b1);
      ex(C_REF, -2, -1, -1, -1, 1, 1'b1);
`else
      ex(C_REF, -2, -1, -1, -1, -1, 1'b1);
`endif
      send(1'b0, 1, 2, 0, 8'h00);
      k = 0;
      while (k < 400 && cmd != 3'(C_REF)) begin
         @(negedge clk);
         k++;
      end
      check("ref_issued", cmd == 3'(C_REF), $sformatf("got cmd=%0d after %0d cycles, need REF", cmd, k));
      @(negedge clk);
      check("ref_busy_low", refresh_busy == 1'b0, $sformatf("got %b, need 0", refresh_busy));
      ex_act(1, 2, -1);
      ex_rd(1, 1, 2, 8'h4B);
      ex_close(1);
      send(1'b0, 1, 2, 1, 8'h00);
      drain("drain_refresh");

      // Reset asserted while waiting out tRCD
      do_reset();
      ex_act(2, 3, -1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 13'(2*1024 + 3*8 + 4 + i);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rst_b = 1'b0;
      #1;
      check("rst_mid_cmd", (cmd == 3'd0) && (bank_sel == '0), $sformatf("got cmd=%0d bank_sel=%h, need 0/00", cmd, bank_sel));
      check("rst_mid_rsp", rsp_valid == 1'b0, $sformatf("got %b, need 0", rsp_valid));
      @(negedge clk);
      rst_b = 1'b1;
      check("rst_mid_ready", req_ready == 1'b1, $sformatf("got %b, need 1", req_ready));
      repeat (20) @(negedge clk);
      drain("drain_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
